// File: rtl/uart_rx_fifo.sv
// UART receiver (start/data/optional parity/stop, break detect) feeding a show-ahead FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit sample point.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int IW           = $clog2(DATA_BITS);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int EW           = DATA_BITS + 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int START_PT     = HALF_BIT;
`else
    localparam int START_PT     = HALF_BIT - 1;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 rx_meta_q, rx_s_q;
    logic                 samp, push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one cycle after the nominal sample point, so history holds sample-1 and sample.
    logic rx_h1_q, rx_h2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rx_s_q;
            rx_h2_q <= rx_h1_q;
        end
    end
    assign samp = (rx_h2_q & rx_h1_q) | (rx_h2_q & rx_s_q) | (rx_h1_q & rx_s_q);
`else
    assign samp = rx_s_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: if (cnt_q == CW'(START_PT)) begin
                cnt_d = '0;
                if (!samp) begin
                    state_d = DATA;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d   = '0;
                shreg_d = {samp, shreg_q[DATA_BITS-1:1]};
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(DATA_BITS - 1))
                    state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d   = '0;
                perr_d  = samp ^ (^shreg_q) ^ (PARITY_MODE == 2);
                state_d = STOP;
            end
            STOP: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d   = '0;
                push    = 1'b1;
                state_d = samp ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, wr_en;
    logic [EW-1:0] head;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop   = data_ready & ~empty;
    // A pop in the push cycle frees the slot, so a full FIFO still accepts the frame.
    assign wr_en = push & (~full | pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
        ovf_d = ovf_q;
        if (push && full && !pop) ovf_d = 1'b1;
        else if (overflow_clr)    ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {perr_q, ~samp, shreg_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign head       = empty ? '0 : mem_q[rd_ptr_q];
    assign data_out   = head[DATA_BITS-1:0];
    assign frame_err  = head[DATA_BITS];
    assign parity_err = head[DATA_BITS+1];
    assign data_valid = ~empty;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: instance A at 115200 baud 8N1, instance B fast-baud 8E1, both depth 4,
// checked against a queue model of received entries.
module tb_uart_rx_fifo;
    localparam int CA = 434;
    localparam int CB = 16;
    localparam int HB = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rdy_a, clr_a, rx_b, rdy_b, clr_b;
    logic [7:0] dout_a, dout_b;
    logic       vld_a, perr_a, ferr_a, ovf_a, vld_b, perr_b, ferr_b, ovf_b;
    logic [2:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .data_out(dout_a), .data_valid(vld_a),
        .data_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overflow(ovf_a),
        .overflow_clr(clr_a), .fifo_count(cnt_a));

    uart_rx_fifo #(.CLOCK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY_MODE(1), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .data_out(dout_b), .data_valid(vld_b),
        .data_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overflow(ovf_b),
        .overflow_clr(clr_b), .fifo_count(cnt_b));

    int n_chk = 0;
    int n_err = 0;

    // Model entries are {parity_err, frame_err, data}.
    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic       oa, ob;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string t, input logic vld, input logic [7:0] d,
                             input logic pe, input logic fe, input logic ov,
                             input logic [2:0] c, input int n, input logic [9:0] h,
                             input logic eov);
        chk({t, ".cnt"},  32'(c),   32'(n));
        chk({t, ".vld"},  32'(vld), 32'(n != 0));
        chk({t, ".ovf"},  32'(ov),  32'(eov));
        chk({t, ".data"}, 32'(d),   32'(h[7:0]));
        chk({t, ".ferr"}, 32'(fe),  32'(h[8]));
        chk({t, ".perr"}, 32'(pe),  32'(h[9]));
    endtask

    task automatic chk_a(input string t);
        logic [9:0] h;
        h = (qa.size() != 0) ? qa[0] : 10'h0;
        chk_state(t, vld_a, dout_a, perr_a, ferr_a, ovf_a, cnt_a, qa.size(), h, oa);
    endtask

    task automatic chk_b(input string t);
        logic [9:0] h;
        h = (qb.size() != 0) ? qb[0] : 10'h0;
        chk_state(t, vld_b, dout_b, perr_b, ferr_b, ovf_b, cnt_b, qb.size(), h, ob);
    endtask

    task automatic send_a(input logic [7:0] d, input logic sb);
        logic [9:0] bits;
        bits = {sb, d, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rx_a = bits[i];
            repeat (CA) @(posedge clk);
            #1;
        end
        rx_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (qa.size() < 4) qa.push_back({1'b0, ~sb, d});
        else oa = 1'b1;
    endtask

    task automatic pop_a();
        rdy_a = 1'b1;
        @(posedge clk); #1;
        rdy_a = 1'b0;
        if (qa.size() != 0) void'(qa.pop_front());
    endtask

    task automatic pop_b();
        rdy_b = 1'b1;
        @(posedge clk); #1;
        rdy_b = 1'b0;
        if (qb.size() != 0) void'(qb.pop_front());
    endtask

    // Frame on B with exact push-cycle checks; optional pop / overflow_clr in the push cycle.
    task automatic send_b(input logic [7:0] d, input logic pb, input logic sb,
                          input logic dp, input logic dc);
        logic [10:0] bits;
        logic [9:0]  ent;
        logic        ep;
        int          k, e;
        bits = {sb, pb, d, 1'b0};
        ep   = ($countones(d) % 2) == 1;
        ent  = {pb != ep, ~sb, d};
        k    = 3 + HB + 10 * CB + MAJ;
        @(posedge clk); #1;
        e = 0;
        for (int i = 0; i < 11; i++) begin
            rx_b = bits[i];
            for (int j = 0; j < CB; j++) begin
                if (e == k - 1) begin
                    chk_b("b.pre");
                    rdy_b = dp;
                    clr_b = dc;
                end
                @(posedge clk); #1;
                e++;
                if (e == k) begin
                    rdy_b = 1'b0;
                    clr_b = 1'b0;
                    if (dp && qb.size() != 0) void'(qb.pop_front());
                    if (qb.size() < 4) begin
                        qb.push_back(ent);
                        if (dc) ob = 1'b0;
                    end else begin
                        ob = 1'b1;
                    end
                    chk_b("b.push");
                end
            end
        end
        rx_b = 1'b1;
        repeat ($urandom_range(4, 20)) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rx_a = 1'b1; rdy_a = 1'b0; clr_a = 1'b0;
        rx_b = 1'b1; rdy_b = 1'b0; clr_b = 1'b0;
        oa = 1'b0; ob = 1'b0;
        #2;
        chk_a("rst.a");
        chk_b("rst.b");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send_a(8'hA5, 1'b1);
        chk_a("a5");
        pop_a();
        chk_a("a5.pop");
        pop_a();
        chk_a("empty.pop");

        rx_a = 1'b0;
        repeat (100) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (CA) @(posedge clk);
        #1;
        chk_a("glitch");

        for (int i = 0; i < 5; i++) send_a(8'($urandom), 1'b1);
        chk_a("ovf");
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        oa = 1'b0;
        chk_a("ovf.clr");
        for (int i = 0; i < 4; i++) begin
            pop_a();
            chk_a("ovf.drain");
        end

        rx_a = 1'b0;
        repeat (20 * CA) @(posedge clk);
        #1;
        qa.push_back({1'b0, 1'b1, 8'h00});
        chk_a("break.low");
        rx_a = 1'b1;
        repeat (2 * CA) @(posedge clk);
        #1;
        chk_a("break.high");
        send_a(8'h3C, 1'b1);
        chk_a("break.next");
        pop_a();
        chk_a("break.pop1");
        pop_a();
        chk_a("break.pop2");

        send_a(8'h81, 1'b1);
        chk_a("pre.rst");
        rx_a = 1'b0;
        repeat (CA) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (CA) @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (CA / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        qa.delete(); qb.delete(); oa = 1'b0; ob = 1'b0;
        chk_a("mid.rst.a");
        chk_b("mid.rst.b");
        rx_a = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (CA) @(posedge clk);
        #1;
        chk_a("post.rst");
        send_a(8'h5A, 1'b1);
        chk_a("5a");
        pop_a();
        chk_a("5a.pop");

        send_b(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        send_b(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_b(); chk_b("par.pop1");
        pop_b(); chk_b("par.pop2");

        for (int i = 0; i < 4; i++) send_b(8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
        send_b(8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
        send_b(8'h12, 1'b0, 1'b1, 1'b0, 1'b1);
        send_b(8'h34, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pop_b();
            chk_b("full.drain");
        end

        for (int i = 0; i < 40; i++) begin
            send_b(8'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 1)) begin
                pop_b();
                chk_b("rnd.pop");
            end
            if ($urandom_range(0, 5) == 0) begin
                clr_b = 1'b1;
                @(posedge clk); #1;
                clr_b = 1'b0;
                ob = 1'b0;
                chk_b("rnd.clr");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: line rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer), HALF_BIT = CLKS_PER_BIT/2.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-004 SHALL have parameter PARITY_MODE, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries, power of two, at least 2.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on the rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-009 SHALL have port data_out, output, DATA_BITS: FIFO head data, show-ahead.
REQ-010 SHALL have port data_valid, output, 1: FIFO not empty.
REQ-011 SHALL have port data_ready, input, 1: pops the head when data_valid is 1.
REQ-012 SHALL have port parity_err, output, 1: head entry had a parity mismatch.
REQ-013 SHALL have port frame_err, output, 1: head entry had a low stop bit.
REQ-014 SHALL have port overflow, output, 1: sticky, a frame was dropped because the FIFO was full.
REQ-015 SHALL have port overflow_clr, input, 1: synchronous clear of overflow.
REQ-016 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.

Function
REQ-017 SHALL pass rx through a 2-flop synchroniser, reset value 1; all decoding uses the synchronised signal rx_s.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP and BREAK, with a bit-clock counter cnt and a bit index idx.
REQ-019 In IDLE, rx_s = 0 SHALL move the FSM to START with cnt = 0.
REQ-020 In START, at cnt = HALF_BIT-1 the FSM SHALL sample the line: 0 -> DATA with cnt = 0 and idx = 0; 1 -> IDLE (glitch rejected, nothing pushed).
REQ-021 In DATA, at cnt = CLKS_PER_BIT-1 the FSM SHALL sample bit idx LSB-first; after bit DATA_BITS-1 it SHALL go to PARITY if PARITY_MODE != 0, otherwise to STOP.
REQ-022 In PARITY, the sampled bit SHALL be compared with the XOR of the data bits (even) or its inverse (odd); a mismatch sets the entry's parity flag.
REQ-023 In STOP, the FIFO SHALL be pushed on the sample cycle with {parity flag, frame flag = ~sample, data}; the FSM then goes to IDLE if the sample is 1, or to BREAK if it is 0.
REQ-024 BREAK SHALL hold until rx_s = 1, then go to IDLE, so that a held-low line yields exactly one errored entry.
REQ-025 Latency SHALL be: entry visible (data_valid = 1) the cycle after the stop-bit sample.
REQ-026 When the FIFO is full, a push SHALL be discarded and overflow set to 1; if a pop occurs in the same cycle, the push SHALL be accepted and overflow left unchanged.
REQ-027 A pop when empty SHALL be ignored; simultaneous push and pop on a non-empty FIFO SHALL leave fifo_count unchanged.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 If overflow_clr and a setting event occur in the same cycle, the set SHALL win.
REQ-030 When empty, data_out, parity_err and frame_err SHALL be 0.

Reset
REQ-031 Asserting rst_n low SHALL at once force: FSM IDLE, cnt 0, idx 0, synchroniser 1, FIFO empty, fifo_count 0, data_valid 0, data_out 0, parity_err 0, frame_err 0, overflow 0.
REQ-032 Reset during a frame SHALL abandon that frame without a push.
REQ-033 After rst_n rises, reception SHALL restart only on the next falling edge seen in IDLE.

Configuration
REQ-034 Macro UART_RX_MAJORITY_EN defined: every sample point SHALL be a 2-of-3 majority of rx_s at sample-1, sample and sample+1, with the decision on the sample+1 cycle and all later timing shifted by one cycle.
REQ-035 Macro UART_RX_MAJORITY_EN undefined: each bit SHALL be a single rx_s sample at the sample cycle.

Verification (CLOCK_FREQ = 50e6, BAUD_RATE = 115200, so CLKS_PER_BIT = 434)
REQ-036 Frame 0xA5 in 8N1 -> one entry 0xA5, both error flags 0, fifo_count 1; data_ready pulse -> data_valid 0.
REQ-037 PARITY_MODE = 1, send 0x03 with parity bit 1 -> entry 0x03 with parity_err 1; send again with parity bit 0 -> parity_err 0.
REQ-038 Low pulse of 100 clk on idle line -> no entry, FSM back in IDLE.
REQ-039 FIFO_DEPTH = 4, send 5 frames with no pops -> fifo_count 4, overflow 1, head equals frame 1; overflow_clr -> overflow 0.
REQ-040 Line held low for 20 bit times -> exactly one entry 0x00 with frame_err 1, none further until the line goes high and then falls again.
REQ-041 rst_n pulsed low mid-DATA -> all outputs zero and no entry; a following frame 0x5A is received correctly.
